// File: rtl/spi_master.sv
// SPI master: one DATA_W-bit word per start, per-transfer CPOL/CPHA/bit order/SCK divider, NUM_CS active-low selects.
// Optional define SPI_MASTER_LOOPBACK_EN adds a loopback input that feeds mosi back into the sampler.
module spi_master #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned NUM_CS = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              pol,
    input  logic              pha,
    input  logic              lsb_first,
    input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic              mosi,
    output logic              sck,
    output logic [NUM_CS-1:0] cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  clk_div_q, clk_div_d;
    logic [CNT_W-1:0]  edge_q, edge_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              pol_q, pol_d;
    logic              pha_q, pha_d;
    logic              lsb_q, lsb_d;
    logic              sck_q, sck_d;
    logic              mosi_q, mosi_d;
    logic              done_q, done_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;

    logic              do_edge;
    logic [CNT_W-1:0]  edge_idx;
    logic [CNT_W-1:0]  bit_idx;
    logic              sample_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic lb_q, lb_d;
    assign sample_bit = lb_q ? mosi_q : miso;
`else
    assign sample_bit = miso;
`endif

    // Bit 'idx' of the transfer in wire order (idx 0 goes out first).
    function automatic logic pick_bit(input logic [DATA_W-1:0] word, input logic lsb,
                                      input logic [CNT_W-1:0] idx);
        logic [DATA_W-1:0] sh;
        sh = lsb ? (word >> idx) : (word << idx);
        return lsb ? sh[0] : sh[DATA_W-1];
    endfunction

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        clk_div_d = clk_div_q;
        edge_d    = edge_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        pol_d     = pol_q;
        pha_d     = pha_q;
        lsb_d     = lsb_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        done_d    = 1'b0;
        do_edge   = 1'b0;
        edge_idx  = edge_q + 1'b1;
        bit_idx   = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
        lb_d      = lb_q;
`endif

        if (state_q != IDLE) begin
            div_d = (div_q == '0) ? clk_div_q : div_q - 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                sck_d  = pol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                if (start) begin
                    state_d   = LEAD;
                    div_d     = clk_div;
                    clk_div_d = clk_div;
                    tx_d      = tx_data;
                    pol_d     = pol;
                    pha_d     = pha;
                    lsb_d     = lsb_first;
                    edge_d    = '0;
                    rx_sh_d   = '0;
                    mosi_d    = pha ? 1'b0 : pick_bit(tx_data, lsb_first, '0);
`ifdef SPI_MASTER_LOOPBACK_EN
                    lb_d      = loopback;
`endif
                    for (int unsigned i = 0; i < NUM_CS; i++) begin
                        cs_n_d[i] = (cs_sel != CS_W'(i));
                    end
                end
            end
            LEAD: begin
                if (div_q == '0) begin
                    state_d  = SHIFT;
                    do_edge  = 1'b1;
                    edge_idx = '0;
                    edge_d   = '0;
                end
            end
            SHIFT: begin
                if (div_q == '0) begin
                    if (edge_q == LAST_EDGE) begin
                        state_d = TRAIL;
                    end else begin
                        do_edge = 1'b1;
                        edge_d  = edge_idx;
                    end
                end
            end
            TRAIL: begin
                if (div_q == '0) begin
                    state_d   = IDLE;
                    sck_d     = pol_q;
                    mosi_d    = 1'b0;
                    cs_n_d    = '1;
                    rx_data_d = rx_sh_q;
                    done_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // edge_idx[0]==0 is a leading edge; the sampling edge is the one whose parity equals pha.
        if (do_edge) begin
            sck_d   = ~sck_q;
            bit_idx = {1'b0, edge_idx[CNT_W-1:1]};
            if (edge_idx[0] == pha_q) begin
                rx_sh_d = lsb_q ? {sample_bit, rx_sh_q[DATA_W-1:1]}
                                : {rx_sh_q[DATA_W-2:0], sample_bit};
            end else if (!edge_idx[0]) begin
                mosi_d = pick_bit(tx_q, lsb_q, bit_idx);
            end else if (bit_idx != LAST_BIT) begin
                mosi_d = pick_bit(tx_q, lsb_q, bit_idx + 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            clk_div_q <= '0;
            edge_q    <= '0;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            pol_q     <= 1'b0;
            pha_q     <= 1'b0;
            lsb_q     <= 1'b0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= '1;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            clk_div_q <= clk_div_d;
            edge_q    <= edge_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            pol_q     <= pol_d;
            pha_q     <= pha_d;
            lsb_q     <= lsb_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
`ifdef SPI_MASTER_LOOPBACK_EN
            lb_q      <= lb_d;
`endif
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of 8-bit transfers plus hand-written 16-bit, back-to-back and reset sequences.
module tb_spi_master;

    localparam int unsigned NCS8  = 4;
    localparam int unsigned NCS16 = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        pol, pha, lsb_first;
    logic [7:0]  clk_div;
    logic        start8, start16;
    logic [7:0]  tx8, rx8;
    logic [15:0] tx16, rx16;
    logic [1:0]  cs_sel8;
    logic [2:0]  cs_sel16;
    logic        miso8, miso16, mosi8, mosi16, sck8, sck16;
    logic        busy8, busy16, done8, done16;
    logic [3:0]  cs_n8;
    logic [4:0]  cs_n16;
    logic        mirror, slave_miso;

    int checks = 0;
    int errors = 0;

    assign miso8  = mirror ? mosi8 : slave_miso;
    assign miso16 = mosi16;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(8), .NUM_CS(NCS8), .DIV_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .tx_data(tx8), .cs_sel(cs_sel8),
        .clk_div(clk_div), .pol(pol), .pha(pha), .lsb_first(lsb_first), .miso(miso8),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .mosi(mosi8), .sck(sck8), .cs_n(cs_n8), .busy(busy8), .done(done8), .rx_data(rx8)
    );

    spi_master #(.DATA_W(16), .NUM_CS(NCS16), .DIV_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .tx_data(tx16), .cs_sel(cs_sel16),
        .clk_div(clk_div), .pol(pol), .pha(pha), .lsb_first(lsb_first), .miso(miso16),
`ifdef SPI_MASTER_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .mosi(mosi16), .sck(sck16), .cs_n(cs_n16), .busy(busy16), .done(done16), .rx_data(rx16)
    );

    typedef struct packed {
        logic       pol;
        logic       pha;
        logic       lsb;
        logic [7:0] div;
        logic [1:0] cs;
        logic [7:0] tx;
        logic       mirror;
        logic [7:0] slave;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic sbit(input logic [7:0] w, input logic lsb, input int unsigned i);
        return lsb ? w[i] : w[7-i];
    endfunction

    // One 8-bit transfer with a behavioural slave; checks timing, selects, both data directions.
    task automatic run8(input vec_t v);
        int unsigned h, cyc, last, edges, bad_gap, bad_cs, busy_cnt, done_cyc, sb, ms;
        logic        prev, leading;
        logic [7:0]  m_word;
        logic [3:0]  exp_cs;
        h = v.div + 1;
        pol = v.pol; pha = v.pha; lsb_first = v.lsb; clk_div = v.div;
        cs_sel8 = v.cs; tx8 = v.tx; mirror = v.mirror; slave_miso = 1'b0;
        tick; tick;
        check("idle_sck", sck8, v.pol);
        exp_cs = '1;
        if (v.cs < NCS8) exp_cs[v.cs] = 1'b0;
        start8 = 1'b1; tick; start8 = 1'b0;
        cyc = 1; last = 1; edges = 0; bad_gap = 0; bad_cs = 0; busy_cnt = 0; done_cyc = 0;
        sb = 0; ms = 0; m_word = '0;
        if (!v.pha) begin
            slave_miso = sbit(v.slave, v.lsb, 0);
            sb = 1;
        end
        prev = sck8;
        while (cyc < 400) begin
            if (busy8) begin
                busy_cnt++;
                if (cs_n8 !== exp_cs) bad_cs++;
            end
            if (done8) begin
                done_cyc = cyc;
                break;
            end
            if (sck8 !== prev) begin
                edges++;
                if (cyc - last != h) bad_gap++;
                last = cyc;
                leading = (sck8 != v.pol);
                if (leading != v.pha) begin
                    if (ms < 8) m_word[v.lsb ? ms : 7 - ms] = mosi8;
                    ms++;
                end else if (sb < 8) begin
                    slave_miso = sbit(v.slave, v.lsb, sb);
                    sb++;
                end
            end
            prev = sck8;
            tick;
            cyc++;
        end
        check("done_time", done_cyc, 1 + 18 * h);
        check("busy_cycles", busy_cnt, 18 * h);
        check("sck_edges", edges, 16);
        check("half_period", bad_gap, 0);
        check("cs_during", bad_cs, 0);
        check("rx_data", rx8, v.exp_rx);
        check("mosi_word", m_word, v.tx);
        check("done_cs_busy", {cs_n8, busy8}, {4'hF, 1'b0});
        check("done_sck", sck8, v.pol);
        tick;
        check("done_pulse_1cyc", done8, 1'b0);
    endtask

    // 16-bit LSB-first mode-0 transfer with miso looped to mosi externally.
    task automatic run16(input logic [15:0] tx, input logic [2:0] cs);
        int unsigned cyc, ne, bad_cs, busy_cnt, done_cyc;
        logic        prev;
        logic [15:0] seq;
        logic [4:0]  exp_cs;
        pol = 1'b0; pha = 1'b0; lsb_first = 1'b1; clk_div = 8'd0;
        tx16 = tx; cs_sel16 = cs;
        tick;
        exp_cs = '1;
        if (cs < NCS16) exp_cs[cs] = 1'b0;
        start16 = 1'b1; tick; start16 = 1'b0;
        cyc = 1; ne = 0; bad_cs = 0; busy_cnt = 0; done_cyc = 0; seq = '0;
        prev = sck16;
        while (cyc < 200) begin
            if (busy16) begin
                busy_cnt++;
                if (cs_n16 !== exp_cs) bad_cs++;
            end
            if (done16) begin
                done_cyc = cyc;
                break;
            end
            if (sck16 !== prev && sck16 == 1'b1) begin
                if (ne < 16) seq[ne] = mosi16;
                ne++;
            end
            prev = sck16;
            tick;
            cyc++;
        end
        check("w16_done_time", done_cyc, 35);
        check("w16_busy_cycles", busy_cnt, 34);
        check("w16_mosi_order", seq, tx);
        check("w16_cs_during", bad_cs, 0);
        check("w16_rx", rx16, tx);
        check("w16_done_cs", cs_n16, 5'h1F);
    endtask

    initial begin
        int unsigned cyc, edges, extra;
        logic        prev;

        vecs[0] = '{pol:1'b0, pha:1'b0, lsb:1'b0, div:8'd0, cs:2'd0, tx:8'hA5, mirror:1'b1, slave:8'h00, exp_rx:8'hA5};
        vecs[1] = '{pol:1'b0, pha:1'b1, lsb:1'b0, div:8'd3, cs:2'd1, tx:8'h5A, mirror:1'b0, slave:8'h3C, exp_rx:8'h3C};
        vecs[2] = '{pol:1'b1, pha:1'b0, lsb:1'b0, div:8'd3, cs:2'd3, tx:8'hC3, mirror:1'b0, slave:8'h3C, exp_rx:8'h3C};
        vecs[3] = '{pol:1'b1, pha:1'b1, lsb:1'b0, div:8'd3, cs:2'd2, tx:8'h96, mirror:1'b0, slave:8'h3C, exp_rx:8'h3C};
        vecs[4] = '{pol:1'b0, pha:1'b0, lsb:1'b1, div:8'd1, cs:2'd0, tx:8'h01, mirror:1'b0, slave:8'h3C, exp_rx:8'h3C};
        vecs[5] = '{pol:1'b1, pha:1'b1, lsb:1'b1, div:8'd0, cs:2'd1, tx:8'hB4, mirror:1'b0, slave:8'hC5, exp_rx:8'hC5};

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        pol = 1'b1; pha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
        tx8 = '0; tx16 = '0; cs_sel8 = '0; cs_sel16 = '0; mirror = 1'b0; slave_miso = 1'b0;
        repeat (3) tick;
        check("rst_sck", sck8, 1'b0);
        check("rst_outputs", {mosi8, cs_n8, busy8, done8}, {1'b0, 4'hF, 1'b0, 1'b0});
        check("rst_rx", rx8, 8'h00);
        rst = 1'b0;
        tick; tick;
        check("idle_pol1_sck", sck8, 1'b1);
        check("idle_outputs", {mosi8, cs_n8, busy8, done8}, {1'b0, 4'hF, 1'b0, 1'b0});
        check("idle_rx", rx8, 8'h00);

        for (int i = 0; i < 6; i++) begin
            run8(vecs[i]);
        end

        run16(16'h8001, 3'd2);
        run16(16'h00F1, 3'd5);

        // Back-to-back: start in the done cycle, then a mid-transfer start that must be ignored.
        pol = 1'b0; pha = 1'b0; lsb_first = 1'b0; clk_div = 8'd0;
        cs_sel8 = 2'd1; mirror = 1'b1; tx8 = 8'h6E;
        tick;
        start8 = 1'b1; tick; start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 60) begin
            tick;
            cyc++;
        end
        check("b2b_first_done", cyc, 19);
        check("b2b_gap_cs_high", cs_n8, 4'hF);
        check("b2b_first_rx", rx8, 8'h6E);
        tx8 = 8'h1F; start8 = 1'b1; tick; start8 = 1'b0;
        cyc = 1;
        check("b2b_second_cs", {cs_n8, busy8}, {4'b1101, 1'b1});
        repeat (4) begin
            tick;
            cyc++;
        end
        tx8 = 8'hFF; cs_sel8 = 2'd3; start8 = 1'b1; tick; cyc++; start8 = 1'b0;
        check("busy_start_cs", cs_n8, 4'b1101);
        while (!done8 && cyc < 60) begin
            tick;
            cyc++;
        end
        check("b2b_second_done", cyc, 19);
        check("b2b_second_rx", rx8, 8'h1F);
        extra = 0;
        repeat (25) begin
            tick;
            if (busy8 || done8) extra++;
        end
        check("no_queued_xfer", extra, 0);

        // Reset at SHIFT edge 5 with pol=1 so sck must drop to its reset value.
        pol = 1'b1; tx8 = 8'hC9; cs_sel8 = 2'd0;
        tick; tick;
        start8 = 1'b1; tick; start8 = 1'b0;
        cyc = 1; edges = 0; prev = sck8;
        while (edges < 5 && cyc < 40) begin
            tick;
            cyc++;
            if (sck8 !== prev) edges++;
            prev = sck8;
        end
        check("rst_reach_edge5", edges, 5);
        rst = 1'b1; tick; rst = 1'b0;
        check("midrst_sck", sck8, 1'b0);
        check("midrst_outputs", {mosi8, cs_n8, busy8, done8}, {1'b0, 4'hF, 1'b0, 1'b0});
        check("midrst_rx", rx8, 8'h00);
        extra = 0;
        repeat (30) begin
            tick;
            if (done8) extra++;
        end
        check("midrst_no_done", extra, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
